// File: rtl/bp_be_dcache_pkg.sv
// Shared D$ definitions: processor configs, LCE command width lookup,
// the watchdog stall-limit default and a count-width helper.
package bp_be_dcache_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_inv_cfg,
        e_bp_half_core_cfg
    } bp_params_e;

    localparam int bp_lce_cmd_stall_limit_gp = 1024;

    // Flat LCE command width per processor config.
    function automatic int bp_lce_cmd_width(input bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg:       return 64;
            e_bp_half_core_cfg: return 96;
            default:            return 128;
        endcase
    endfunction

    // Width of an occupancy counter that must represent 0..els inclusive.
    function automatic int bp_cnt_width(input int els);
        return $clog2(els + 1);
    endfunction

endpackage

// File: rtl/bp_be_dcache_lce_cmd_stall_watchdog.sv
// Head-of-queue stall watchdog: saturating count of consecutive unconsumed
// head cycles plus a sticky flag that only clear_i can drop.
module bp_be_dcache_lce_cmd_stall_watchdog
    import bp_be_dcache_pkg::*;
#(
    parameter int stall_limit_p = bp_lce_cmd_stall_limit_gp
)(
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic v_i,
    input  logic yumi_i,
    input  logic clear_i,
    output logic stall_o
);

    localparam int cnt_width_lp = $clog2(stall_limit_p + 1);

    logic [cnt_width_lp-1:0] stall_cnt_r;
    logic                    stall_r;
    logic                    stalled;
    logic                    set_stall;

    assign stalled   = v_i & ~yumi_i;
    assign set_stall = stalled & (stall_cnt_r == cnt_width_lp'(stall_limit_p - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt_r <= '0;
            stall_r     <= 1'b0;
        end else begin
            if (!stalled)
                stall_cnt_r <= '0;
            else if (stall_cnt_r != cnt_width_lp'(stall_limit_p))
                stall_cnt_r <= stall_cnt_r + 1'b1;

            // Set has priority over a coincident clear.
            if (set_stall)
                stall_r <= 1'b1;
            else if (clear_i)
                stall_r <= 1'b0;
        end
    end

    assign stall_o = stall_r;

endmodule

// File: rtl/bp_be_dcache_lce_cmd_buffer.sv
// Elastic CCE->LCE command buffer: valid/ready in, valid/yumi out, with a
// head stall watchdog. Define BP_LCE_CMD_BUF_BYPASS_EN for zero-latency empty bypass.
module bp_be_dcache_lce_cmd_buffer
    import bp_be_dcache_pkg::*;
#(
    parameter bp_params_e bp_params_p   = e_bp_inv_cfg,
    parameter int         els_p         = 4,
    parameter int         stall_limit_p = bp_lce_cmd_stall_limit_gp,
    parameter int         lce_cmd_width_lp = bp_lce_cmd_width(bp_params_p),
    parameter int         cnt_width_lp     = bp_cnt_width(els_p)
)(
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [lce_cmd_width_lp-1:0] lce_cmd_i,
    input  logic                        lce_cmd_v_i,
    output logic                        lce_cmd_ready_o,

    output logic [lce_cmd_width_lp-1:0] lce_cmd_o,
    output logic                        lce_cmd_v_o,
    input  logic                        lce_cmd_yumi_i,

    output logic [cnt_width_lp-1:0]     count_o,
    output logic                        stall_o,
    input  logic                        clear_stall_i
);

    localparam int ptr_width_lp = $clog2(els_p);

    logic [lce_cmd_width_lp-1:0] storage_r [els_p];
    logic [ptr_width_lp-1:0]     wr_ptr_r, rd_ptr_r;
    logic [cnt_width_lp-1:0]     count_r;

    logic empty;
    logic deq;
    logic deq_stored;
    logic enq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty           = (count_r == '0);
    assign lce_cmd_ready_o = (count_r < cnt_width_lp'(els_p));
    assign deq             = lce_cmd_yumi_i & lce_cmd_v_o;

`ifdef BP_LCE_CMD_BUF_BYPASS_EN
    // A command consumed straight off the input while empty is never stored.
    logic bypass_deq;
    assign bypass_deq  = empty & deq;
    assign deq_stored  = deq & ~bypass_deq;
    assign enq         = lce_cmd_v_i & lce_cmd_ready_o & ~bypass_deq;
    assign lce_cmd_v_o = empty ? lce_cmd_v_i : 1'b1;
    assign lce_cmd_o   = empty ? (lce_cmd_v_i ? lce_cmd_i : '0) : storage_r[rd_ptr_r];
`else
    assign deq_stored  = deq;
    assign enq         = lce_cmd_v_i & lce_cmd_ready_o;
    assign lce_cmd_v_o = ~empty;
    assign lce_cmd_o   = empty ? '0 : storage_r[rd_ptr_r];
`endif

    // NOTE: storage is deliberately left out of reset; count/pointers alone
    // define which entries are live, so stale data is never observable.
    always_ff @(posedge clk_i) begin
        if (enq)
            storage_r[wr_ptr_r] <= lce_cmd_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq)
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (deq_stored)
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({enq, deq_stored})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count_o = count_r;

    bp_be_dcache_lce_cmd_stall_watchdog #(
        .stall_limit_p (stall_limit_p)
    ) watchdog (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (lce_cmd_v_o),
        .yumi_i    (lce_cmd_yumi_i),
        .clear_i   (clear_stall_i),
        .stall_o   (stall_o)
    );

    // The LCE must never consume a head that is not presented.
    yumi_without_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) !(lce_cmd_yumi_i && !lce_cmd_v_o)
    );

endmodule

// File: tb/tb_bp_be_dcache_lce_cmd_buffer.sv
// Bench for bp_be_dcache_lce_cmd_buffer: directed steps plus random traffic
// against a queue-based reference model.
module tb_bp_be_dcache_lce_cmd_buffer;
    import bp_be_dcache_pkg::*;

    localparam int W    = bp_lce_cmd_width(e_bp_inv_cfg);
    localparam int ELS  = 4;
    localparam int LIM  = 8;
    localparam int ELS3 = 3;
`ifdef BP_LCE_CMD_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [W-1:0]                 lce_cmd_i, lce_cmd_o;
    logic                         lce_cmd_v_i, lce_cmd_ready_o, lce_cmd_v_o, lce_cmd_yumi_i;
    logic [bp_cnt_width(ELS)-1:0] count_o;
    logic                         stall_o, clear_stall_i;

    logic [W-1:0]                  cmd3_i, cmd3_o;
    logic                          v3_i, ready3_o, v3_o, yumi3_i;
    logic [bp_cnt_width(ELS3)-1:0] count3_o;
    logic                          stall3_o, clear3_i;

    bp_be_dcache_lce_cmd_buffer #(
        .bp_params_p(e_bp_inv_cfg), .els_p(ELS), .stall_limit_p(LIM)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .lce_cmd_i(lce_cmd_i), .lce_cmd_v_i(lce_cmd_v_i), .lce_cmd_ready_o(lce_cmd_ready_o),
        .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o), .lce_cmd_yumi_i(lce_cmd_yumi_i),
        .count_o(count_o), .stall_o(stall_o), .clear_stall_i(clear_stall_i)
    );

    bp_be_dcache_lce_cmd_buffer #(
        .bp_params_p(e_bp_inv_cfg), .els_p(ELS3), .stall_limit_p(16)
    ) dut3 (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .lce_cmd_i(cmd3_i), .lce_cmd_v_i(v3_i), .lce_cmd_ready_o(ready3_o),
        .lce_cmd_o(cmd3_o), .lce_cmd_v_o(v3_o), .lce_cmd_yumi_i(yumi3_i),
        .count_o(count3_o), .stall_o(stall3_o), .clear_stall_i(clear3_i)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents, length of current stall run, sticky flag.
    logic [W-1:0] q[$];
    logic [W-1:0] q3[$];
    int           run  = 0;
    bit           flag = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic step(input logic v, input logic [W-1:0] d, input logic y, input logic c);
        bit           byp_head, ev, deq, acc;
        logic [W-1:0] ed;
        byp_head = BYP && (q.size() == 0) && v;
        ev       = (q.size() != 0) || byp_head;
        ed       = (q.size() != 0) ? q[0] : (byp_head ? d : '0);
        deq      = y && ev;
        acc      = v && (q.size() < ELS) && !(byp_head && deq);

        lce_cmd_v_i    = v;
        lce_cmd_i      = d;
        lce_cmd_yumi_i = deq;
        clear_stall_i  = c;
        #1;
        check("v_o",   64'(lce_cmd_v_o),     64'(ev));
        check("data",  64'(lce_cmd_o),       64'(ed));
        check("count", 64'(count_o),         64'(q.size()));
        check("ready", 64'(lce_cmd_ready_o), 64'(q.size() < ELS));
        check("stall", 64'(stall_o),         64'(flag));

        @(posedge clk_i);
        #1;
        if (deq && q.size() != 0) void'(q.pop_front());
        if (acc) q.push_back(d);
        if (ev && !deq) run++;
        else            run = 0;
        if (ev && !deq && run == LIM) flag = 1'b1;
        else if (c)                   flag = 1'b0;

        lce_cmd_v_i    = 1'b0;
        lce_cmd_yumi_i = 1'b0;
        clear_stall_i  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < ELS + 1; i++)
            if (q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        lce_cmd_i = '0; lce_cmd_v_i = 1'b0; lce_cmd_yumi_i = 1'b0; clear_stall_i = 1'b0;
        cmd3_i = '0; v3_i = 1'b0; yumi3_i = 1'b0; clear3_i = 1'b0;

        #2;
        check("rst_v_o",   64'(lce_cmd_v_o),     64'(0));
        check("rst_count", 64'(count_o),         64'(0));
        check("rst_ready", 64'(lce_cmd_ready_o), 64'(1));
        check("rst_data",  64'(lce_cmd_o),       64'(0));
        check("rst_stall", 64'(stall_o),         64'(0));
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;

        // Fill to full, reject a fifth, then drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, W'(32'hA1 + i), 1'b0, 1'b0);
        check("full_count", 64'(count_o),         64'(4));
        check("full_ready", 64'(lce_cmd_ready_o), 64'(0));
        step(1'b1, W'(32'hA5), 1'b0, 1'b0);
        check("full_reject", 64'(count_o), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("drain_order", 64'(lce_cmd_o), 64'(32'hA1 + i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("drained_v_o", 64'(lce_cmd_v_o), 64'(0));

        // Full plus yumi: input dropped, ready returns, re-present accepted.
        for (int i = 0; i < 4; i++) step(1'b1, W'(32'hB1 + i), 1'b0, 1'b0);
        step(1'b1, W'(32'hB5), 1'b1, 1'b0);
        check("fy_count", 64'(count_o),         64'(3));
        check("fy_ready", 64'(lce_cmd_ready_o), 64'(1));
        step(1'b1, W'(32'hB5), 1'b0, 1'b0);
        check("fy_reaccept", 64'(count_o), 64'(4));
        drain();

        // Watchdog: sets after exactly LIM stalled cycles, sticky, clearable.
        step(1'b1, W'(32'hC1), 1'b0, 1'b0);
        for (int i = 0; i < LIM - 1; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("stall_before_limit", 64'(stall_o), 64'(0));
        step(1'b0, '0, 1'b0, 1'b0);
        check("stall_at_limit", 64'(stall_o), 64'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        check("stall_sticky", 64'(stall_o), 64'(1));
        step(1'b0, '0, 1'b0, 1'b1);
        check("stall_cleared", 64'(stall_o), 64'(0));
        step(1'b1, W'(32'hC2), 1'b0, 1'b0);
        for (int i = 0; i < LIM - 1; i++) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("stall_set_wins", 64'(stall_o), 64'(1));
        step(1'b0, '0, 1'b1, 1'b1);
        check("stall_clear2", 64'(stall_o), 64'(0));

`ifdef BP_LCE_CMD_BUF_BYPASS_EN
        drain();
        step(1'b1, W'(32'h55), 1'b1, 1'b0);
        check("byp_count", 64'(count_o), 64'(0));
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 2) != 0), {$urandom, $urandom},
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));

        // Asynchronous reset with three entries buffered.
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, W'(32'hD1 + i), 1'b0, 1'b0);
        #2 reset_n_i = 1'b0;
        #1;
        check("arst_v_o",   64'(lce_cmd_v_o),     64'(0));
        check("arst_count", 64'(count_o),         64'(0));
        check("arst_ready", 64'(lce_cmd_ready_o), 64'(1));
        check("arst_data",  64'(lce_cmd_o),       64'(0));
        q.delete();
        run  = 0;
        flag = 1'b0;
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        step(1'b1, W'(32'hE1), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Three-deep instance: steady enqueue+yumi across pointer wrap.
        v3_i = 1'b1; cmd3_i = W'(32'h100);
        @(posedge clk_i);
        #1;
        q3.push_back(W'(32'h100));
        for (int i = 0; i < 100; i++) begin
            v3_i = 1'b1; cmd3_i = W'(32'h200 + i); yumi3_i = 1'b1;
            #1;
            check("wrap_count", 64'(count3_o), 64'(1));
            check("wrap_data",  64'(cmd3_o),   64'(q3[0]));
            @(posedge clk_i);
            #1;
            void'(q3.pop_front());
            q3.push_back(W'(32'h200 + i));
        end
        v3_i = 1'b0; yumi3_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
